// File: rtl/uart_master_core.sv
// Single-channel 8N1 UART with a 16550-style byte register file.
// 16x-oversampled receiver, buffered transmitter, programmable divisor, modem pins and loopback.
module uart_master_core #(
    parameter int CLK_FREQ = 27000000,
    parameter int BAUD     = 115200
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    input  logic       I_TX_EN,
    input  logic [2:0] I_WADDR,
    input  logic [7:0] I_WDATA,
    input  logic       I_RX_EN,
    input  logic [2:0] I_RADDR,
    output logic [7:0] O_RDATA,
    input  logic       SIN,
    output logic       RxRDYn,
    output logic       SOUT,
    output logic       TxRDYn,
    output logic       DDIS,
    output logic       INTR,
    input  logic       DCDn,
    input  logic       CTSn,
    input  logic       DSRn,
    input  logic       RIn,
    output logic       DTRn,
    output logic       RTSn
);

    localparam logic [15:0] DEFAULT_DIV = 16'((CLK_FREQ + 8 * BAUD) / (16 * BAUD));

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } bit_state_t;

    logic [3:0] ier;
    logic [7:0] lcr, mcr, scr, dll, dlm, thr, rbr;
    logic       thr_full, dr, oe, fe, intr_q;
    logic       dlab, loopback;

    assign dlab     = lcr[7];
    assign loopback = mcr[4];

    logic wr_thr, wr_dll, wr_dlm, rd_rbr, rd_lsr;
    assign wr_thr = I_TX_EN && (I_WADDR == 3'd0) && !dlab;
    assign wr_dll = I_TX_EN && (I_WADDR == 3'd0) && dlab;
    assign wr_dlm = I_TX_EN && (I_WADDR == 3'd1) && dlab;
    assign rd_rbr = I_RX_EN && (I_RADDR == 3'd0) && !dlab;
    assign rd_lsr = I_RX_EN && (I_RADDR == 3'd5);

    // Baud generator: one 16x tick every divisor clocks, divisor 0 behaves as 1.
    logic [15:0] divisor, div_m1, baud_cnt;
    logic        tick;
    assign divisor = {dlm, dll};
    assign div_m1  = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    assign tick    = (baud_cnt >= div_m1);

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET)               baud_cnt <= '0;
        else if (wr_dll || wr_dlm) baud_cnt <= '0;
        else if (tick)             baud_cnt <= '0;
        else                       baud_cnt <= baud_cnt + 16'd1;
    end

    // Transmitter
    bit_state_t tx_st, tx_n;
    logic [3:0] tx_tcnt, tx_tcnt_n;
    logic [2:0] tx_bcnt, tx_bcnt_n;
    logic [7:0] tx_sh, tx_sh_n;
    logic       tx_load, tx_line, tx_idle;

    assign tx_idle = (tx_st == S_IDLE);
    assign tx_line = (tx_st == S_START) ? 1'b0 :
                     (tx_st == S_DATA)  ? tx_sh[0] : 1'b1;

    always_comb begin
        tx_n      = tx_st;
        tx_tcnt_n = tx_tcnt;
        tx_bcnt_n = tx_bcnt;
        tx_sh_n   = tx_sh;
        tx_load   = 1'b0;
        case (tx_st)
            S_IDLE: begin
                if (thr_full) begin
                    tx_n      = S_START;
                    tx_tcnt_n = '0;
                    tx_sh_n   = thr;
                    tx_load   = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tx_tcnt == 4'd15) begin
                        tx_n      = S_DATA;
                        tx_tcnt_n = '0;
                        tx_bcnt_n = '0;
                    end else begin
                        tx_tcnt_n = tx_tcnt + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tx_tcnt == 4'd15) begin
                        tx_tcnt_n = '0;
                        tx_sh_n   = {1'b0, tx_sh[7:1]};
                        if (tx_bcnt == 3'd7) tx_n = S_STOP;
                        else                 tx_bcnt_n = tx_bcnt + 3'd1;
                    end else begin
                        tx_tcnt_n = tx_tcnt + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (tx_tcnt == 4'd15) tx_n = S_IDLE;
                    else                  tx_tcnt_n = tx_tcnt + 4'd1;
                end
            end
            default: tx_n = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            tx_st   <= S_IDLE;
            tx_tcnt <= '0;
            tx_bcnt <= '0;
            tx_sh   <= '0;
        end else begin
            tx_st   <= tx_n;
            tx_tcnt <= tx_tcnt_n;
            tx_bcnt <= tx_bcnt_n;
            tx_sh   <= tx_sh_n;
        end
    end

    // Receiver input: loopback takes the internal TX line ahead of the synchronizer.
    logic [1:0] rx_sync;
    logic       rx_in;
    assign rx_in = rx_sync[1];

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) rx_sync <= 2'b11;
        else         rx_sync <= {rx_sync[0], loopback ? tx_line : SIN};
    end

    bit_state_t rx_st, rx_n;
    logic [3:0] rx_tcnt, rx_tcnt_n;
    logic [2:0] rx_bcnt, rx_bcnt_n;
    logic [7:0] rx_sh, rx_sh_n;
    logic       rx_done;

    always_comb begin
        rx_n      = rx_st;
        rx_tcnt_n = rx_tcnt;
        rx_bcnt_n = rx_bcnt;
        rx_sh_n   = rx_sh;
        rx_done   = 1'b0;
        case (rx_st)
            S_IDLE: begin
                if (!rx_in) begin
                    rx_n      = S_START;
                    rx_tcnt_n = '0;
                end
            end
            S_START: begin
                // The eighth tick lands mid start bit; a high line here was a glitch.
                if (tick) begin
                    if (rx_tcnt == 4'd7) begin
                        if (rx_in) begin
                            rx_n = S_IDLE;
                        end else begin
                            rx_n      = S_DATA;
                            rx_tcnt_n = '0;
                            rx_bcnt_n = '0;
                        end
                    end else begin
                        rx_tcnt_n = rx_tcnt + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt_n = '0;
                        rx_sh_n   = {rx_in, rx_sh[7:1]};
                        if (rx_bcnt == 3'd7) rx_n = S_STOP;
                        else                 rx_bcnt_n = rx_bcnt + 3'd1;
                    end else begin
                        rx_tcnt_n = rx_tcnt + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_tcnt == 4'd15) begin
                        rx_done = 1'b1;
                        rx_n    = S_IDLE;
                    end else begin
                        rx_tcnt_n = rx_tcnt + 4'd1;
                    end
                end
            end
            default: rx_n = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            rx_st   <= S_IDLE;
            rx_tcnt <= '0;
            rx_bcnt <= '0;
            rx_sh   <= '0;
        end else begin
            rx_st   <= rx_n;
            rx_tcnt <= rx_tcnt_n;
            rx_bcnt <= rx_bcnt_n;
            rx_sh   <= rx_sh_n;
        end
    end

    // Modem inputs are asynchronous; present them synchronized and active-high.
    logic [3:0] modem_s1, modem_s2;
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            modem_s1 <= 4'hF;
            modem_s2 <= 4'hF;
        end else begin
            modem_s1 <= {DCDn, RIn, DSRn, CTSn};
            modem_s2 <= modem_s1;
        end
    end

    logic [7:0] lsr, msr, iir;
    logic       thre, temt;
    assign thre = !thr_full;
    assign temt = thre && tx_idle;
    assign lsr  = {1'b0, temt, thre, 1'b0, fe, 1'b0, oe, dr};
    assign msr  = {~modem_s2, 4'b0000};

    always_comb begin
        iir = 8'h01;
        if (ier[2] && (oe || fe)) iir = 8'h06;
        else if (ier[0] && dr)    iir = 8'h04;
        else if (ier[1] && thre)  iir = 8'h02;
    end

    always_comb begin
        O_RDATA = 8'h00;
        case (I_RADDR)
            3'd0: O_RDATA = dlab ? dll : rbr;
            3'd1: O_RDATA = dlab ? dlm : {4'b0000, ier};
            3'd2: O_RDATA = iir;
            3'd3: O_RDATA = lcr;
            3'd4: O_RDATA = mcr;
            3'd5: O_RDATA = lsr;
            3'd6: O_RDATA = msr;
            3'd7: O_RDATA = scr;
            default: O_RDATA = 8'h00;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            ier      <= '0;
            lcr      <= 8'h03;
            mcr      <= '0;
            scr      <= '0;
            dll      <= DEFAULT_DIV[7:0];
            dlm      <= DEFAULT_DIV[15:8];
            thr      <= '0;
            thr_full <= 1'b0;
            rbr      <= '0;
            dr       <= 1'b0;
            oe       <= 1'b0;
            fe       <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            if (I_TX_EN) begin
                case (I_WADDR)
                    3'd0: if (dlab) dll <= I_WDATA; else thr <= I_WDATA;
                    3'd1: if (dlab) dlm <= I_WDATA; else ier <= I_WDATA[3:0];
                    3'd3: lcr <= I_WDATA;
                    3'd4: mcr <= I_WDATA;
                    3'd7: scr <= I_WDATA;
                    default: ;
                endcase
            end
            // A write landing with the shifter load keeps the new byte pending.
            if (wr_thr)       thr_full <= 1'b1;
            else if (tx_load) thr_full <= 1'b0;

            if (rd_rbr) dr <= 1'b0;
            if (rd_lsr) begin
                oe <= 1'b0;
                fe <= 1'b0;
            end
            // A completing byte overrides any same-cycle read clear.
            if (rx_done) begin
                rbr <= rx_sh;
                dr  <= 1'b1;
                fe  <= ~rx_in;
                oe  <= dr;
            end
            intr_q <= ~iir[0];
        end
    end

    assign INTR   = intr_q;
    assign SOUT   = loopback ? 1'b1 : tx_line;
    assign RxRDYn = ~dr;
    assign TxRDYn = ~thre;
    assign DDIS   = ~I_RX_EN;
    assign DTRn   = ~mcr[0];
    assign RTSn   = ~mcr[1];

endmodule

// File: tb/tb_uart_master_core.sv
// Directed bench for uart_master_core: registers, TX/RX framing, overrun/framing errors,
// loopback with a fast divisor, interrupts, modem pins and mid-frame reset.
module tb_uart_master_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0, rx_en = 1'b0;
    logic [2:0] waddr = '0, raddr = '0;
    logic [7:0] wdata = '0;
    logic       sin = 1'b1;
    logic       dcdn = 1'b1, ctsn = 1'b1, dsrn = 1'b1, rin = 1'b1;
    logic [7:0] rdata;
    logic       rxrdyn, sout, txrdyn, ddis, intr, dtrn, rtsn;

    int errs = 0;
    int checks = 0;

    uart_master_core dut (
        .I_CLK(clk), .I_RESET(rst), .I_TX_EN(tx_en), .I_WADDR(waddr), .I_WDATA(wdata),
        .I_RX_EN(rx_en), .I_RADDR(raddr), .O_RDATA(rdata), .SIN(sin), .RxRDYn(rxrdyn),
        .SOUT(sout), .TxRDYn(txrdyn), .DDIS(ddis), .INTR(intr),
        .DCDn(dcdn), .CTSn(ctsn), .DSRn(dsrn), .RIn(rin), .DTRn(dtrn), .RTSn(rtsn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        waddr = a; wdata = d; tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp, input logic strobe);
        @(negedge clk);
        raddr = a; rx_en = strobe;
        #1 chk(tag, {8'h00, rdata}, {8'h00, exp});
        @(negedge clk);
        rx_en = 1'b0;
    endtask

    // 240 clocks per bit at the reset divisor of 15
    task automatic send_bits(input logic [7:0] b);
        sin = 1'b0;
        cyc(240);
        for (int i = 0; i < 8; i++) begin
            sin = b[i];
            cyc(240);
        end
    endtask

    // A bad stop bit is held only past its mid-sample so the trailing low cannot become a frame.
    task automatic send_stop(input logic s);
        if (s) begin
            sin = 1'b1;
            cyc(240);
        end else begin
            sin = 1'b0;
            cyc(150);
            sin = 1'b1;
            cyc(240);
        end
    endtask

    logic [9:0] frame;
    int elapsed;
    logic sout_bad;

    initial begin
        // reset state
        cyc(3);
        chk("rst_sout", sout, 1);
        chk("rst_txrdyn", txrdyn, 0);
        chk("rst_rxrdyn", rxrdyn, 1);
        chk("rst_intr", intr, 0);
        chk("rst_dtrn", dtrn, 1);
        chk("rst_rtsn", rtsn, 1);
        @(negedge clk) rst = 1'b0;
        rd("rst_lsr", 3'd5, 8'h60, 0);
        rd("rst_lcr", 3'd3, 8'h03, 0);
        rd("rst_iir", 3'd2, 8'h01, 0);
        wr(3'd3, 8'h80);
        rd("rst_dll", 3'd0, 8'd15, 0);
        rd("rst_dlm", 3'd1, 8'd0, 0);
        wr(3'd3, 8'h03);

        // TX of 0x06
        @(negedge clk);
        waddr = 3'd0; wdata = 8'h06; tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        chk("tx_thr_full", txrdyn, 1);
        @(negedge clk);
        chk("tx_thr_empty", txrdyn, 0);
        frame = {1'b1, 8'h06, 1'b0};
        cyc(120);
        chk("tx_bit0", sout, frame[0]);
        for (int k = 1; k < 10; k++) begin
            cyc(240);
            chk($sformatf("tx_bit%0d", k), sout, frame[k]);
        end
        rd("tx_lsr_busy", 3'd5, 8'h20, 0);
        cyc(140);
        rd("tx_lsr_temt", 3'd5, 8'h60, 0);

        // RX of 0x01
        send_bits(8'h01);
        chk("rx_pre_stop", rxrdyn, 1);
        send_stop(1'b1);
        chk("rx_ready", rxrdyn, 0);
        rd("rx_rbr", 3'd0, 8'h01, 1);
        chk("rx_cleared", rxrdyn, 1);

        // overrun then framing error
        send_bits(8'h03); send_stop(1'b1);
        send_bits(8'h16); send_stop(1'b1);
        rd("ovr_lsr", 3'd5, 8'h63, 0);
        rd("ovr_rbr", 3'd0, 8'h16, 0);
        send_bits(8'h55); send_stop(1'b0);
        rd("fe_lsr", 3'd5, 8'h6B, 1);
        rd("fe_lsr_clr", 3'd5, 8'h61, 0);
        rd("fe_rbr", 3'd0, 8'h55, 1);
        chk("fe_rxrdyn", rxrdyn, 1);

        // short low pulse is rejected
        sin = 1'b0; cyc(40); sin = 1'b1; cyc(300);
        chk("glitch_rxrdyn", rxrdyn, 1);
        rd("glitch_lsr", 3'd5, 8'h60, 0);

        // loopback at divisor 1: 160-clock frame, SOUT held idle
        wr(3'd3, 8'h83);
        wr(3'd0, 8'h01);
        wr(3'd1, 8'h00);
        rd("lb_dll", 3'd0, 8'h01, 0);
        wr(3'd3, 8'h03);
        wr(3'd4, 8'h10);
        wr(3'd0, 8'h2C);
        elapsed = 0;
        sout_bad = 1'b0;
        while (rxrdyn && elapsed < 400) begin
            @(negedge clk);
            elapsed++;
            if (!sout) sout_bad = 1'b1;
        end
        chk("lb_done", rxrdyn, 0);
        chk("lb_time", (elapsed >= 140 && elapsed <= 200) ? 16'd1 : 16'd0, 1);
        chk("lb_sout_idle", sout_bad, 0);
        rd("lb_rbr", 3'd0, 8'h2C, 1);
        cyc(20);
        rd("lb_lsr", 3'd5, 8'h60, 0);
        wr(3'd4, 8'h00);
        wr(3'd3, 8'h80);
        wr(3'd0, 8'h0F);
        wr(3'd3, 8'h03);

        // interrupts
        wr(3'd1, 8'h01);
        rd("irq_iir_idle", 3'd2, 8'h01, 0);
        send_bits(8'hA5); send_stop(1'b1);
        chk("irq_intr_on", intr, 1);
        rd("irq_iir_rx", 3'd2, 8'h04, 0);
        rd("irq_rbr", 3'd0, 8'hA5, 1);
        @(negedge clk);
        chk("irq_intr_off", intr, 0);
        rd("irq_iir_clr", 3'd2, 8'h01, 0);
        wr(3'd1, 8'h02);
        rd("irq_iir_thre", 3'd2, 8'h02, 0);
        cyc(2);
        chk("irq_intr_thre", intr, 1);
        wr(3'd1, 8'h00);

        // scratch, modem status and control, driver disable
        wr(3'd7, 8'h5A);
        rd("scr", 3'd7, 8'h5A, 0);
        ctsn = 1'b0; dcdn = 1'b0;
        cyc(3);
        rd("msr", 3'd6, 8'h90, 0);
        wr(3'd4, 8'h03);
        chk("dtrn_on", dtrn, 0);
        chk("rtsn_on", rtsn, 0);
        chk("ddis_idle", ddis, 1);
        @(negedge clk);
        raddr = 3'd7; rx_en = 1'b1;
        #1 chk("ddis_read", ddis, 0);
        @(negedge clk) rx_en = 1'b0;

        // reset in the middle of a frame (0x16, data bit 0 is low)
        wr(3'd0, 8'h16);
        cyc(300);
        chk("mid_sout_low", sout, 0);
        #2 rst = 1'b1;
        #1 chk("mid_rst_sout", sout, 1);
        chk("mid_rst_txrdyn", txrdyn, 0);
        chk("mid_rst_dtrn", dtrn, 1);
        @(negedge clk) rst = 1'b0;
        rd("mid_lsr", 3'd5, 8'h60, 0);
        rd("mid_lcr", 3'd3, 8'h03, 0);
        rd("mid_scr", 3'd7, 8'h00, 0);
        chk("mid_rxrdyn", rxrdyn, 1);
        chk("mid_intr", intr, 0);
        wr(3'd3, 8'h80);
        rd("mid_dll", 3'd0, 8'd15, 0);
        wr(3'd3, 8'h03);
        cyc(400);
        chk("mid_sout_idle", sout, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uart_master_core.md
Name: uart_master_core

Overview:
- Single-channel UART with a 16550-style 8-register byte interface, used by the image-receive front end to exchange protocol bytes (0x01/0x06/0x03/0x16) with a host.
- Provides 16x-oversampled RX, TX shifter with holding register, line status, programmable baud divisor and modem-control pins.
- Frame format is fixed at 8N1.

Parameters:
- CLK_FREQ, 27000000, system clock frequency in Hz.
- BAUD, 115200, reset baud rate. Reset divisor DEFAULT_DIV = round(CLK_FREQ/(16*BAUD)), which is 15 at the defaults.

Ports:
- I_CLK  in  1  system clock; all logic on its rising edge.
- I_RESET  in  1  reset, asynchronous, active-high.
- I_TX_EN  in  1  write strobe; register write at the clock edge where it is 1.
- I_WADDR  in  3  write register address.
- I_WDATA  in  8  write data.
- I_RX_EN  in  1  read strobe; qualifies read side effects.
- I_RADDR  in  3  read register address.
- O_RDATA  out  8  read data, combinational from I_RADDR and register state.
- SIN  in  1  serial input, idle high.
- RxRDYn  out  1  low while a received byte is pending (~LSR.DR).
- SOUT  out  1  serial output, idle high.
- TxRDYn  out  1  low while THR is empty (~LSR.THRE).
- DDIS  out  1  driver disable = ~I_RX_EN.
- INTR  out  1  interrupt, high when IIR[0]==0.
- DCDn, CTSn, DSRn, RIn  in  1 each  modem inputs, active-low, visible in MSR.
- DTRn, RTSn  out  1 each  ~MCR[0], ~MCR[1].

Behaviour:
- Register map by address, 0 to 7:
  - 0: read RBR, write THR; when LCR[7] (DLAB) = 1, reads and writes DLL instead.
  - 1: IER[3:0]; when DLAB = 1, DLM instead.
  - 2: read IIR, write FCR (write accepted, no effect).
  - 3: LCR; only bit 7 is functional, other bits are stored and read back.
  - 4: MCR; bit0 DTR, bit1 RTS, bit4 loopback.
  - 5: LSR, read-only: bit0 DR, bit1 OE, bit3 FE, bit5 THRE, bit6 TEMT, other bits 0.
  - 6: MSR[7:4] = {~DCDn, ~RIn, ~DSRn, ~CTSn} (synchronized); MSR[3:0] = 0.
  - 7: SCR, scratch register.
- Reset values:
  - Registers: IER=0, LCR=0x03, MCR=0, SCR=0, LSR=0x60, RBR=0, divisor=DEFAULT_DIV.
  - Outputs: SOUT=1, RxRDYn=1, TxRDYn=0, INTR=0, DTRn=1, RTSn=1.
  - RX and TX state machines return to IDLE.
  - Asserting reset mid-frame aborts the frame; SOUT goes to 1 immediately.
- Baud tick:
  - A 16-bit counter produces one 16x tick every divisor clocks.
  - A divisor of 0 is treated as 1.
  - Writing DLL or DLM reloads the counter.
- RX path:
  - SIN passes through a 2-flop synchronizer.
  - IDLE -> START on a sampled 0. At tick 8 the line is re-checked; if it is 1, return to IDLE (glitch).
  - DATA: 8 bits, LSB first, each sampled at mid-bit (every 16 ticks).
  - STOP: sampled at mid-bit.
  - On stop sample: RBR <= byte, DR <= 1, FE <= ~stop, OE <= DR_old. A new byte overwrites RBR on overrun.
  - RX then returns to IDLE and can detect the next start bit immediately.
- Read side effects, only when I_RX_EN=1 at the clock edge:
  - I_RADDR=0 with DLAB=0 clears DR at that edge; O_RDATA shows RBR during that cycle.
  - I_RADDR=5 clears OE and FE.
  - If a byte completes in the same cycle as an RBR read, the new byte wins and DR stays 1.
- TX path:
  - A THR write clears THRE and TEMT. THR write while THRE=0 overwrites THR.
  - When the shifter is idle and THR is full, THR loads into the shifter the next clock and THRE returns to 1.
  - Frame: start 0, 8 data bits LSB first, stop 1; each bit lasts 16 ticks.
  - TEMT=1 when THR is empty and the shifter is idle.
- Loopback (MCR[4]=1): the RX input is the internal TX line, SOUT is held at 1, and SIN is ignored.
- IIR, in priority order:
  - 0x06 if IER[2] and (OE|FE).
  - Else 0x04 if IER[0] and DR.
  - Else 0x02 if IER[1] and THRE.
  - Else 0x01.
  - Level-sensitive; no clear-on-read.
- INTR = IIR[0]==0, registered one cycle.

Test Plan:
- Reset: pulse I_RESET mid-operation -> SOUT=1, TxRDYn=0, RxRDYn=1, LSR read=0x60, LCR read=0x03, divisor=15.
- TX: write 0x06 to addr 0 -> TxRDYn high for 1 cycle then low. SOUT shows 0,0,1,1,0,0,0,0,0,1, each bit 240 clocks. TEMT=1 after the stop bit.
- RX: drive 0x01 8N1 at 240 clocks/bit on SIN -> RxRDYn low after the stop mid-sample, O_RDATA=0x01 at addr 0. One read strobe -> RxRDYn high next cycle.
- Overrun/framing: send 0x03 then 0x16 without reading -> LSR=0x63, RBR=0x16. Send a frame with stop=0 -> FE set. Read LSR -> OE and FE cleared.
- Divisor/loopback: set DLAB, write DLL=1, DLM=0, clear DLAB, set MCR=0x10, write 0x2C -> RBR=0x2C after 160 clocks, SOUT stays 1.
- Interrupt: IER=0x01, receive 0xA5 -> INTR=1, IIR=0x04. Read RBR -> INTR=0 with IIR=0x01.
